// File: rtl/mul_int_mul_radix_iter_if.sv
// Valid/ready stream bundle for the iterative multiplier.
// The producer drives val and msg; the consumer drives rdy.
interface mul_int_mul_radix_iter_if #(
  parameter int W = 1
);
  logic         val;
  logic         rdy;
  logic [W-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/mul_int_mul_radix_iter.sv
// Iterative radix-2^RADIX_LOG2 multiplier: sign-magnitude operands, shift-add
// partial products, early exit once the remaining multiplier bits are zero.
module mul_int_mul_radix_iter #(
  parameter int NBITS        = 32,
  parameter int RADIX_LOG2   = 2,
  parameter bit FULL_PRODUCT = 1'b0
) (
  input logic                      clk,
  input logic                      reset,
  mul_int_mul_radix_iter_if.slave  istream,
  mul_int_mul_radix_iter_if.master ostream
);
  localparam int OW    = FULL_PRODUCT ? 2*NBITS : NBITS;
  localparam int STEPS = NBITS / RADIX_LOG2;
  localparam int CW    = $clog2(STEPS + 1);

  if (NBITS % RADIX_LOG2 != 0) begin : g_bad_nbits
    $fatal(1, "NBITS must be a multiple of RADIX_LOG2");
  end
  if (RADIX_LOG2 != 1 && RADIX_LOG2 != 2 && RADIX_LOG2 != 4) begin : g_bad_radix
    $fatal(1, "RADIX_LOG2 must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic               sign;
  logic [2*NBITS-1:0] a_reg;
  logic [NBITS-1:0]   b_reg;
  logic [2*NBITS-1:0] acc;
  logic [CW-1:0]      counter;
  logic               rdy_q;
  logic               val_q;
  logic [OW-1:0]      msg_q;

  logic               mode_in;
  logic [NBITS-1:0]   a_in;
  logic [NBITS-1:0]   b_in;
  logic [NBITS-1:0]   a_mag;
  logic [NBITS-1:0]   b_mag;
  logic [2*NBITS-1:0] partial;
  logic [2*NBITS-1:0] acc_next;
  logic [NBITS-1:0]   b_next;
  logic [CW-1:0]      cnt_next;
  logic               last_step;
  logic [2*NBITS-1:0] result;

  assign mode_in = istream.msg[2*NBITS];
  assign a_in    = istream.msg[2*NBITS-1:NBITS];
  assign b_in    = istream.msg[NBITS-1:0];

  // Negating the most negative value wraps back onto itself, which is exactly
  // its unsigned magnitude, so no extra bit is needed.
  assign a_mag = (mode_in && a_in[NBITS-1]) ? -a_in : a_in;
  assign b_mag = (mode_in && b_in[NBITS-1]) ? -b_in : b_in;

  assign partial   = a_reg * {{(2*NBITS-RADIX_LOG2){1'b0}}, b_reg[RADIX_LOG2-1:0]};
  assign acc_next  = acc + partial;
  assign b_next    = b_reg >> RADIX_LOG2;
  assign cnt_next  = counter + CW'(1);
  assign last_step = (b_next == '0) || (cnt_next == CW'(STEPS));
  assign result    = sign ? -acc_next : acc_next;

  assign istream.rdy = rdy_q;
  assign ostream.val = val_q;
  assign ostream.msg = msg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sign    <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      counter <= '0;
      rdy_q   <= 1'b0;
      val_q   <= 1'b0;
      msg_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (istream.val && rdy_q) begin
            sign    <= mode_in & (a_in[NBITS-1] ^ b_in[NBITS-1]);
            a_reg   <= {{NBITS{1'b0}}, a_mag};
            b_reg   <= b_mag;
            acc     <= '0;
            counter <= '0;
            rdy_q   <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc     <= acc_next;
          a_reg   <= a_reg << RADIX_LOG2;
          b_reg   <= b_next;
          counter <= cnt_next;
          if (last_step) begin
            val_q <= 1'b1;
            msg_q <= result[OW-1:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (ostream.rdy) begin
            val_q <= 1'b0;
            msg_q <= '0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_int_mul_radix_iter.sv
// Bench for mul_int_mul_radix_iter: six radix/product-width configurations
// checked against an arithmetic reference model.
module tb_mul_int_mul_radix_iter;
  localparam int NCFG = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCFG-1:0]   in_val = '0;
  logic [NCFG-1:0]   in_rdy;
  logic [NCFG-1:0]   out_val;
  logic [NCFG-1:0]   out_rdy = '0;
  logic [64:0]       in_msg [NCFG];
  logic [63:0]       out_msg [NCFG];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  // Config k: radix 2 for k=0,1; radix 1 for k=2,3; radix 4 for k=4,5; odd k = full product.
  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int R  = (k < 2) ? 2 : ((k < 4) ? 1 : 4);
    localparam bit FP = (k % 2) == 1;
    localparam int OW = FP ? 64 : 32;

    mul_int_mul_radix_iter_if #(.W(65)) in_if ();
    mul_int_mul_radix_iter_if #(.W(OW)) out_if ();

    assign in_if.val  = in_val[k];
    assign in_if.msg  = in_msg[k];
    assign in_rdy[k]  = in_if.rdy;
    assign out_if.rdy = out_rdy[k];
    assign out_val[k] = out_if.val;
    assign out_msg[k] = 64'(out_if.msg);

    mul_int_mul_radix_iter #(.NBITS(32), .RADIX_LOG2(R), .FULL_PRODUCT(FP)) dut (
      .clk     (clk),
      .reset   (reset),
      .istream (in_if),
      .ostream (out_if)
    );
  end

  function automatic int cfg_radix(input int k);
    return (k < 2) ? 2 : ((k < 4) ? 1 : 4);
  endfunction

  function automatic logic [63:0] model(input int k, input logic mode,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (mode) p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
    else      p = {32'b0, a} * {32'b0, b};
    return (k % 2 == 1) ? p : {32'b0, p[31:0]};
  endfunction

  // Number of multiplier digits that must be processed, never fewer than one.
  function automatic int exp_calc(input int k, input logic mode, input logic [31:0] b);
    logic [31:0] mag;
    int bl, c;
    mag = (mode && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
    c = (bl + cfg_radix(k) - 1) / cfg_radix(k);
    return (c == 0) ? 1 : c;
  endfunction

  task automatic send_req(input int k, input logic mode, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] msg, output int lat);
    int guard = 0;
    @(negedge clk);
    in_msg[k] = {mode, a, b};
    in_val[k] = 1'b1;
    while (!in_rdy[k] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_val[k] = 1'b0;
    lat = 1;
    while (!out_val[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    msg = out_msg[k];
    if (!out_val[k]) lat = -1;
  endtask

  task automatic consume(input int k);
    out_rdy[k] = 1'b1;
    @(negedge clk);
    out_rdy[k] = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
        checks++;
        if ({in_rdy[k], out_val[k], out_msg[k]} !== 66'd0) begin
          errors++;
          $display("[TB] FAIL reset_outputs cfg%0d: rdy=%b val=%b msg=%h, expected all 0",
                   k, in_rdy[k], out_val[k], out_msg[k]);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== {NCFG{1'b1}}) begin
      errors++;
      $display("[TB] FAIL reset_release_rdy: got %b expected %b", in_rdy, {NCFG{1'b1}});
    end
    // Abort a long radix-2 transaction partway through its CALC phase.
    in_msg[0] = {1'b0, 32'h3, 32'hFFFF_FFFF};
    in_val[0] = 1'b1;
    @(negedge clk);
    in_val[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_val[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_output: ostream_val seen=%b expected 0", seen);
    end
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_idle: istream_rdy=%b expected 1", in_rdy[0]);
    end
  endtask

  task automatic directed(input string name, input int k, input logic mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_msg, input int exp_c);
    logic [63:0] msg;
    int lat;
    send_req(k, mode, a, b, msg, lat);
    checks++;
    if (msg !== exp_msg) begin
      errors++;
      $display("[TB] FAIL %s_result: got %h expected %h", name, msg, exp_msg);
    end
    checks++;
    if (lat - 1 !== exp_c) begin
      errors++;
      $display("[TB] FAIL %s_calc_cycles: got %0d expected %0d", name, lat - 1, exp_c);
    end
    if (lat > 0) consume(k);
  endtask

  task automatic test_basic();
    directed("u3x5", 0, 1'b0, 32'd3, 32'd5, 64'h0000_000F, 2);
    directed("u7x0", 0, 1'b0, 32'd7, 32'd0, 64'h0, 1);
  endtask

  task automatic test_full_product();
    directed("umax_sq", 1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16);
  endtask

  task automatic test_signed();
    directed("s_m3x5", 1, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2);
    directed("s_min_x_m1_full", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
    directed("s_min_x_m1_low", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
  endtask

  task automatic test_radix_latency();
    directed("r1_u9x5", 2, 1'b0, 32'd9, 32'd5, model(2, 1'b0, 32'd9, 32'd5), exp_calc(2, 1'b0, 32'd5));
    directed("r4_s_m7x256", 5, 1'b1, 32'hFFFF_FFF9, 32'h100,
             model(5, 1'b1, 32'hFFFF_FFF9, 32'h100), exp_calc(5, 1'b1, 32'h100));
    directed("r1_umax", 3, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF,
             model(3, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF), 32);
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [63:0] msg, exp_msg;
    int lat;
    a = $urandom;
    b = $urandom | 32'h8000_0000;
    exp_msg = model(0, 1'b0, a, b);
    send_req(0, 1'b0, a, b, msg, lat);
    checks++;
    if (msg !== exp_msg) begin
      errors++;
      $display("[TB] FAIL bp_result: got %h expected %h", msg, exp_msg);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_val[0] !== 1'b1 || out_msg[0] !== exp_msg || in_rdy[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle%0d: val=%b msg=%h rdy=%b expected 1/%h/0",
                 i, out_val[0], out_msg[0], in_rdy[0], exp_msg);
      end
    end
    consume(0);
    checks++;
    if (in_rdy[0] !== 1'b1 || out_val[0] !== 1'b0 || out_msg[0] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL bp_release: rdy=%b val=%b msg=%h expected 1/0/0",
               in_rdy[0], out_val[0], out_msg[0]);
    end
  endtask

  task automatic test_random_stream(input int k, input int n);
    logic [63:0] expq[$];
    int got = 0;
    fork
      begin : driver
        logic mode;
        logic [31:0] a, b;
        int guard;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          mode = 1'($urandom_range(0, 1));
          a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
          case ($urandom_range(0, 5))
            0: b = $urandom_range(0, 15);
            1: b = 32'h8000_0000;
            2: b = 32'h0;
            3: b = 32'hFFFF_FFFF;
            default: b = $urandom;
          endcase
          in_msg[k] = {mode, a, b};
          in_val[k] = 1'b1;
          guard = 0;
          while (!in_rdy[k] && guard < 500) begin
            @(negedge clk);
            guard++;
          end
          if (!in_rdy[k]) begin
            checks++;
            errors++;
            $display("[TB] FAIL rand_accept_timeout cfg%0d txn%0d: rdy=0 expected 1", k, i);
            in_val[k] = 1'b0;
            break;
          end
          expq.push_back(model(k, mode, a, b));
          @(negedge clk);
          in_val[k] = 1'b0;
        end
      end
      begin : monitor
        int cyc = 0;
        bit held = 1'b0;
        logic [63:0] held_msg = '0;
        while (got < n && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (held) begin
            checks++;
            if (out_val[k] !== 1'b1 || out_msg[k] !== held_msg) begin
              errors++;
              $display("[TB] FAIL rand_stable cfg%0d: val=%b msg=%h expected 1/%h",
                       k, out_val[k], out_msg[k], held_msg);
            end
          end
          out_rdy[k] = ($urandom_range(0, 2) != 0);
          if (out_val[k]) begin
            if (out_rdy[k]) begin
              checks++;
              if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL rand_extra cfg%0d: got %h expected no output", k, out_msg[k]);
              end else if (out_msg[k] !== expq[0]) begin
                errors++;
                $display("[TB] FAIL rand_result cfg%0d txn%0d: got %h expected %h",
                         k, got, out_msg[k], expq[0]);
              end
              if (expq.size() != 0) void'(expq.pop_front());
              got++;
              held = 1'b0;
            end else begin
              held = 1'b1;
              held_msg = out_msg[k];
            end
          end else begin
            held = 1'b0;
          end
        end
        out_rdy[k] = 1'b0;
      end
    join
    checks++;
    if (got !== n || expq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL rand_count cfg%0d: received %0d pending %0d expected %0d/0",
               k, got, expq.size(), n);
    end
  endtask

  initial begin
    for (int k = 0; k < NCFG; k++) in_msg[k] = '0;
    test_reset();
    test_basic();
    test_full_product();
    test_signed();
    test_radix_latency();
    test_backpressure();
    for (int k = 0; k < NCFG; k++) test_random_stream(k, 90);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
